// File: rtl/serial_subtractor_if.sv
// +----------------------------------------------------------------------+
// | serial_subtractor_if: request/result bundle for serial_subtractor    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
// +----------------------------------------------------------------------+
// | serial_subtractor: bit-serial a - b - bin, LSB first, one bit/cycle  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input wire logic      clk,
  input wire logic      rst,
  serial_subtractor_if.slave bus
);

  localparam int             CW     = $clog2(WIDTH + 1);
  localparam logic [1:0]     S_IDLE = 2'd0;
  localparam logic [1:0]     S_RUN  = 2'd1;
  localparam logic [1:0]     S_DONE = 2'd2;
  localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  C_ONE  = CW'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_bout;
  logic [CW-1:0]    r_cnt;

  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_bo;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // single full-subtractor cell fed from the LSBs of the operand shifters
  assign w_x        = r_a[0];
  assign w_y        = r_b[0];
  assign w_d        = w_x ^ w_y ^ r_borrow;
  assign w_bo       = (~w_x & w_y) | (~w_x & r_borrow) | (w_y & r_borrow);
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};

  assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_RUN) && (r_cnt == C_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  w_next = bus.start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (r_state)
      S_RUN:   bus.busy = 1'b1;
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else if (w_accept) begin
      r_a      <= bus.a;
      r_b      <= bus.b;
      r_res    <= '0;
      r_borrow <= bus.bin;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_res    <= w_res_next;
      r_borrow <= w_bo;
      r_cnt    <= r_cnt + C_ONE;
      // result registers only move on completion so they hold across IDLE/RUN
      if (w_last) begin
        r_diff <= w_res_next;
        r_bout <= w_bo;
      end
    end
  end

  assign bus.diff = r_diff;
  assign bus.bout = r_bout;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// +----------------------------------------------------------------------+
// | tb_serial_subtractor: vectors, random ops and corner sequences       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic bin);
    return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called #1 after the accepting edge; returns with the DONE cycle sampled.
  task automatic wait_done(output int n, output int bcnt, output bit excl_bad);
    n = 0; bcnt = 0; excl_bad = 1'b0;
    while (!bus.done && n < 4 * W) begin
      if (bus.busy) bcnt++;
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy && bus.done) excl_bad = 1'b1;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       output int n, output int bcnt, output bit excl_bad);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.bin = bin;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
    wait_done(n, bcnt, excl_bad);
  endtask

  vec_t vecs[8];

  initial begin : main
    int n, bcnt, dones;
    bit excl;
    logic [W:0] e1, e2;
    logic [W-1:0] ra, rb;
    logic rbin;
    bit held_bad;

    total = 0; bad = 0;
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[6] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
    vecs[7] = '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0};

    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    #12;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_diff", 32'(bus.diff), 32'd0);
    check("reset_bout", 32'(bus.bout), 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, n, bcnt, excl);
      check($sformatf("vec%0d_latency", i), 32'(n), 32'(W));
      check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(W));
      check($sformatf("vec%0d_excl", i), 32'(excl), 32'd0);
      check($sformatf("vec%0d_diff", i), 32'(bus.diff), 32'(vecs[i].exp_diff));
      check($sformatf("vec%0d_bout", i), 32'(bus.bout), 32'(vecs[i].exp_bout));
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'd0);
      check($sformatf("vec%0d_idle_hold", i), 32'({bus.bout, bus.diff}),
            32'({vecs[i].exp_bout, vecs[i].exp_diff}));
    end

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      e1 = model(ra, rb, rbin);
      do_op(ra, rb, rbin, n, bcnt, excl);
      check($sformatf("rnd%0d_latency", i), 32'(n), 32'(W));
      check($sformatf("rnd%0d_result", i), 32'({bus.bout, bus.diff}), 32'(e1));
    end

    // start held high through RUN while operands wander
    e1 = model(8'h9C, 8'h3B, 1'b1);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h9C; bus.b = 8'h3B; bus.bin = 1'b1;
    @(posedge clk); #1;
    n = 0; bcnt = 0;
    while (!bus.done && n < 4 * W) begin
      if (bus.busy) bcnt++;
      @(negedge clk);
      bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk); bus.start = 1'b0;
    check("held_busy_cycles", 32'(bcnt), 32'(W));
    check("held_result", 32'({bus.bout, bus.diff}), 32'(e1));
    dones = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("held_extra_done", 32'(dones), 32'd0);

    // back-to-back: new start in the DONE cycle
    e1 = model(8'h10, 8'h21, 1'b0);
    e2 = model(8'hC3, 8'h42, 1'b1);
    do_op(8'h10, 8'h21, 1'b0, n, bcnt, excl);
    check("b2b_first", 32'({bus.bout, bus.diff}), 32'(e1));
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hC3; bus.b = 8'h42; bus.bin = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b_no_idle", 32'(bus.busy), 32'd1);
    n = 0; held_bad = 1'b0;
    while (!bus.done && n < 4 * W) begin
      if ({bus.bout, bus.diff} !== e1) held_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check("b2b_first_held", 32'(held_bad), 32'd0);
    check("b2b_latency", 32'(n), 32'(W));
    check("b2b_second", 32'({bus.bout, bus.diff}), 32'(e2));

    // asynchronous reset in RUN cycle 4
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h77; bus.b = 8'h11; bus.bin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_diff", 32'(bus.diff), 32'd0);
    check("arst_bout", 32'(bus.bout), 32'd0);
    #1 rst = 1'b0;
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("arst_no_done", 32'(dones), 32'd0);

    // start taken on the very first edge after reset release
    @(posedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    bus.start = 1'b1; bus.a = 8'h30; bus.b = 8'h31; bus.bin = 1'b1;
    e1 = model(8'h30, 8'h31, 1'b1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("post_rst_accept", 32'(bus.busy), 32'd1);
    wait_done(n, bcnt, excl);
    check("post_rst_latency", 32'(n), 32'(W));
    check("post_rst_result", 32'({bus.bout, bus.diff}), 32'(e1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
